// File: rtl/isa_pkg.sv
// Shared definitions for the 8-bit instruction format.
// Used by the assembler, the packer and the matching splitter.
package isa_pkg;
  localparam int OPCODE_W = 3;
  localparam int AUX_W    = 3;
  localparam int OPC_LSB  = 0;
  localparam int RT_BIT   = 3;
  localparam int RS_BIT   = 4;
  localparam int AUX_LSB  = 5;
  localparam int INST_W   = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/instruction_assembler_if.sv
// Field-tuple input and memory write port of the instruction assembler.
// The master modport is the assembler; the slave modport is the feeder/memory side.
interface instruction_assembler_if import isa_pkg::*; #(parameter int ADDR_W = 8);
  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] in_opcode;
  logic                in_rt;
  logic                in_rs;
  logic [AUX_W-1:0]    in_aux;
  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [INST_W-1:0]   mem_wdata;

  modport master (
    input  in_valid, in_opcode, in_rt, in_rs, in_aux, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_opcode, in_rt, in_rs, in_aux, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instruction_packer.sv
// Combinational field packer: the exact inverse of the instruction splitter.
module instruction_packer import isa_pkg::*; (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                rt,
  input  logic                rs,
  input  logic [AUX_W-1:0]    aux,
  output logic [INST_W-1:0]   word
);
  always_comb begin
    word                        = '0;
    word[OPC_LSB +: OPCODE_W]   = opcode;
    word[RT_BIT]                = rt;
    word[RS_BIT]                = rs;
    word[AUX_LSB +: AUX_W]      = aux;
  end
endmodule

// File: rtl/instruction_assembler.sv
// Program loader: packs field tuples and writes them to sequential memory addresses
// through a single-entry write register.
module instruction_assembler import isa_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         count,
  instruction_assembler_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    wrap_err
);
  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     remaining;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [INST_W-1:0]   mem_wdata_q;
  logic [INST_W-1:0]   packed_word;
  logic                done_q;
  logic                wrap_err_q;
  logic                in_ready_c;
  logic                accept;
  logic                launch;
  logic                done_next;
  logic                last_tuple;

  instruction_packer u_packer (
    .opcode (bus.in_opcode),
    .rt     (bus.in_rt),
    .rs     (bus.in_rs),
    .aux    (bus.in_aux),
    .word   (packed_word)
  );

  assign in_ready_c = (state == RUN) && (!mem_valid_q || bus.mem_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign launch     = (state == IDLE) && start && !abort && (count != '0);
  assign last_tuple = (remaining == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Abort beats everything, including a same-cycle start or accept.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (count != '0) state_next = RUN;
          else             done_next  = 1'b1;
        end
      end
      RUN: begin
        if (abort)                        state_next = IDLE;
        else if (accept && last_tuple)    state_next = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!mem_valid_q || bus.mem_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write register only reloads on accept, so a stalled write holds address and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      remaining   <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      wrap_err_q  <= 1'b0;
    end else begin
      done_q <= done_next;
      if (launch) begin
        addr       <= base_addr;
        remaining  <= count;
        wrap_err_q <= 1'b0;
      end
      if (abort && state != IDLE) begin
        mem_valid_q <= 1'b0;
      end else if (accept) begin
        mem_valid_q <= 1'b1;
        mem_addr_q  <= addr;
        mem_wdata_q <= packed_word;
        addr        <= addr + ADDR_W'(1);
        remaining   <= remaining - (ADDR_W+1)'(1);
        if (addr == '1 && !last_tuple) wrap_err_q <= 1'b1;
      end else if (bus.mem_ready) begin
        mem_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign wrap_err      = wrap_err_q;
endmodule

// File: tb/tb_instruction_assembler.sv
// Directed self-checking bench for instruction_assembler; inputs change and
// outputs are sampled on the falling clock edge.
module tb_instruction_assembler;
  localparam int ADDR_W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] base_addr;
  logic [8:0] count;
  logic       busy;
  logic       done;
  logic       wrap_err;
  int         checks = 0;
  int         errors = 0;

  instruction_assembler_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_assembler #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .wrap_err  (wrap_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_tuple(input logic v, input logic [2:0] op, input logic rt, input logic rs, input logic [2:0] aux);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_rt     = rt;
    bus.in_rs     = rs;
    bus.in_aux    = aux;
  endtask

  // Leaves the bench on the falling edge where the DUT is already in RUN.
  task automatic begin_load(input logic [7:0] b, input logic [8:0] c);
    start = 1'b1; base_addr = b; count = c;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; count = '0;
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid got %b want 0", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_addr got %h want 00", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_wdata got %h want 00", bus.mem_wdata); end
    checks++; if ({busy, done, wrap_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status got %b want 000", {busy, done, wrap_err}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_pack();
    logic [2:0] op  [3] = '{3'd5, 3'd2, 3'd7};
    logic       rt  [3] = '{1'b1, 1'b0, 1'b1};
    logic       rs  [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0] aux [3] = '{3'd6, 3'd3, 3'd0};
    logic [7:0] wd  [3] = '{8'hCD, 8'h72, 8'h1F};
    logic [7:0] ad  [3] = '{8'h10, 8'h11, 8'h12};
    begin_load(8'h10, 9'd3);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_tuple(1'b1, op[i], rt[i], rs[i], aux[i]);
      step();
      checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid[%0d] got %b want 1", i, bus.mem_valid); end
      checks++; if (bus.mem_addr !== ad[i]) begin errors++; $display("[TB] FAIL single_addr[%0d] got %h want %h", i, bus.mem_addr, ad[i]); end
      checks++; if (bus.mem_wdata !== wd[i]) begin errors++; $display("[TB] FAIL single_wdata[%0d] got %h want %h", i, bus.mem_wdata, wd[i]); end
    end
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_drain_busy got %b want 1", busy); end
    step();
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("[TB] FAIL single_done got done,busy=%b want 10", {done, busy}); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wd [4] = '{8'hE1, 8'hCA, 8'hB3, 8'h9C};
    logic [7:0] ad [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
    logic [2:0] op [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] ax [4] = '{3'd7, 3'd6, 3'd5, 3'd4};
    logic       rt [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       rs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    begin_load(8'h20, 9'd4);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_tuple(1'b1, op[i], rt[i], rs[i], ax[i]);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      step();
      checks++; if ({bus.mem_valid, bus.mem_addr, bus.mem_wdata} !== {1'b1, ad[i], wd[i]}) begin
        errors++; $display("[TB] FAIL b2b_write[%0d] got v=%b a=%h d=%h want v=1 a=%h d=%h", i, bus.mem_valid, bus.mem_addr, bus.mem_wdata, ad[i], wd[i]);
      end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_early_done[%0d] got %b want 0", i, done); end
    end
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    step();
    checks++; if ({done, busy, bus.mem_valid} !== 3'b100) begin errors++; $display("[TB] FAIL b2b_done got done,busy,valid=%b want 100", {done, busy, bus.mem_valid}); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_pulse got %b want 0", done); end
  endtask

  task automatic test_stall();
    begin_load(8'h40, 9'd2);
    bus.mem_ready = 1'b0;
    set_tuple(1'b1, 3'd6, 1'b0, 1'b1, 3'd2);
    step();
    set_tuple(1'b1, 3'd1, 1'b1, 1'b1, 3'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({bus.mem_valid, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h40, 8'h56}) begin
        errors++; $display("[TB] FAIL stall_hold[%0d] got v=%b a=%h d=%h want v=1 a=40 d=56", k, bus.mem_valid, bus.mem_addr, bus.mem_wdata);
      end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready[%0d] got %b want 0", k, bus.in_ready); end
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume_ready got %b want 1", bus.in_ready); end
    step();
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    checks++; if ({bus.mem_valid, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h41, 8'h39}) begin
      errors++; $display("[TB] FAIL stall_second got v=%b a=%h d=%h want v=1 a=41 d=39", bus.mem_valid, bus.mem_addr, bus.mem_wdata);
    end
    step();
    checks++; if ({done, bus.mem_valid} !== 2'b10) begin errors++; $display("[TB] FAIL stall_done got done,valid=%b want 10", {done, bus.mem_valid}); end
  endtask

  task automatic test_wrap();
    logic [7:0] ad [3] = '{8'hFE, 8'hFF, 8'h00};
    begin_load(8'hFE, 9'd3);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_tuple(1'b1, 3'(i + 1), 1'b0, 1'b0, 3'd0);
      step();
      checks++; if ({bus.mem_addr, bus.mem_wdata} !== {ad[i], 8'(i + 1)}) begin
        errors++; $display("[TB] FAIL wrap_write[%0d] got a=%h d=%h want a=%h d=%h", i, bus.mem_addr, bus.mem_wdata, ad[i], 8'(i + 1));
      end
    end
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    step();
    checks++; if ({done, wrap_err} !== 2'b11) begin errors++; $display("[TB] FAIL wrap_done got done,wrap_err=%b want 11", {done, wrap_err}); end
    step();
    checks++; if (wrap_err !== 1'b1) begin errors++; $display("[TB] FAIL wrap_sticky got %b want 1", wrap_err); end
    // Reaching 0xFF on the final tuple is not a wrap; the new start also clears the flag.
    begin_load(8'hFF, 9'd1);
    checks++; if (wrap_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_cleared got %b want 0", wrap_err); end
    set_tuple(1'b1, 3'd7, 1'b1, 1'b1, 3'd7);
    step();
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {8'hFF, 8'hFF}) begin errors++; $display("[TB] FAIL wrap_last got a=%h d=%h want a=ff d=ff", bus.mem_addr, bus.mem_wdata); end
    step();
    checks++; if ({done, wrap_err} !== 2'b10) begin errors++; $display("[TB] FAIL wrap_edge got done,wrap_err=%b want 10", {done, wrap_err}); end
  endtask

  task automatic test_abort();
    begin_load(8'h80, 9'd5);
    bus.mem_ready = 1'b0;
    set_tuple(1'b1, 3'd1, 1'b0, 1'b0, 3'd0);
    step();
    bus.mem_ready = 1'b1;
    set_tuple(1'b1, 3'd2, 1'b0, 1'b0, 3'd0);
    step();
    checks++; if ({bus.mem_valid, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h81, 8'h02}) begin
      errors++; $display("[TB] FAIL abort_pending got v=%b a=%h d=%h want v=1 a=81 d=02", bus.mem_valid, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ready = 1'b0;
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    checks++; if ({bus.mem_valid, busy, done, bus.in_ready} !== 4'b0000) begin
      errors++; $display("[TB] FAIL abort_idle got valid,busy,done,ready=%b want 0000", {bus.mem_valid, busy, done, bus.in_ready});
    end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done got %b want 0", done); end
    begin_load(8'h90, 9'd1);
    bus.mem_ready = 1'b1;
    set_tuple(1'b1, 3'd3, 1'b1, 1'b0, 3'd0);
    step();
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {8'h90, 8'h0B}) begin errors++; $display("[TB] FAIL abort_reload got a=%h d=%h want a=90 d=0b", bus.mem_addr, bus.mem_wdata); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload_done got %b want 1", done); end
  endtask

  task automatic test_zero_count();
    start = 1'b1; base_addr = 8'h55; count = 9'd0;
    step();
    start = 1'b0;
    checks++; if ({done, busy, bus.mem_valid} !== 3'b100) begin errors++; $display("[TB] FAIL zero_done got done,busy,valid=%b want 100", {done, busy, bus.mem_valid}); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_pulse got %b want 0", done); end
    start = 1'b1; abort = 1'b1; count = 9'd2;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL abort_start got busy,done=%b want 00", {busy, done}); end
  endtask

  task automatic test_reset_mid_load();
    begin_load(8'h30, 9'd3);
    bus.mem_ready = 1'b0;
    set_tuple(1'b1, 3'd5, 1'b1, 1'b0, 3'd6);
    step();
    set_tuple(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_valid, bus.in_ready, busy, done} !== 4'b0000) begin
      errors++; $display("[TB] FAIL midreset_ctrl got valid,ready,busy,done=%b want 0000", {bus.mem_valid, bus.in_ready, busy, done});
    end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_bus got a=%h d=%h want 00 00", bus.mem_addr, bus.mem_wdata); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_after got busy,done=%b want 00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_single_pack();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_abort();
    test_zero_count();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_assembler.md
Name: instruction_assembler

Overview:
- Encoder side of the 8-bit instruction format: packs opcode/rt/rs/aux field tuples into 8-bit instruction words.
- Writes packed words into instruction memory at sequential addresses; acts as the program loader ahead of the fetch stage.
- Field input and memory write port both use valid/ready handshakes; one pipeline register on the write side.

Parameters:
ADDR_W, 8, instruction memory address width; a load of up to 2^ADDR_W words is supported.

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load; sampled only in IDLE
abort  input  1  synchronous cancel of the current load
base_addr  input  ADDR_W  first write address, latched on start
count  input  ADDR_W+1  number of instructions to load, latched on start
in_valid  input  1  field tuple valid
in_ready  output  1  assembler accepts a tuple this cycle
in_opcode  input  3  opcode field
in_rt  input  1  rt register select
in_rs  input  1  rs register select
in_aux  input  3  aux/immediate field
mem_valid  output  1  write request valid
mem_ready  input  1  memory accepts the write
mem_addr  output  ADDR_W  write address
mem_wdata  output  8  packed instruction
busy  output  1  high in RUN or DRAIN
done  output  1  one-cycle pulse when a load completes normally
wrap_err  output  1  sticky; set when the address wraps past 2^ADDR_W-1 during a load

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=0; mem_valid=0; mem_addr=0; mem_wdata=0; busy=0; done=0; wrap_err=0; internal address and remaining counters cleared.
- Packing: mem_wdata[2:0]=opcode, [3]=rt, [4]=rs, [7:5]=aux. Any other bit mapping is an error.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - in_ready=0.
  - start with count!=0: latch base_addr into the address counter, latch count into remaining, clear wrap_err, go to RUN.
  - start with count==0: pulse done on the next cycle and stay in IDLE.
- RUN: in_ready = !mem_valid || mem_ready.
  - On in_valid && in_ready, the next cycle has mem_valid=1, mem_wdata=packed tuple, mem_addr=current address (latency 1 cycle).
  - Also on accept: the address increments modulo 2^ADDR_W, and remaining decrements.
  - If the increment wraps from 2^ADDR_W-1 to 0 and remaining after decrement is nonzero, set wrap_err.
  - When remaining reaches 0 on an accept, go to DRAIN.
- Write handshake: mem_addr and mem_wdata are held stable while mem_valid && !mem_ready.
  - mem_valid clears on mem_ready unless a new tuple is accepted in the same cycle.
  - Back-to-back accepts at full throughput are allowed when mem_ready stays high.
- DRAIN:
  - in_ready=0.
  - When mem_valid is 0, or mem_valid && mem_ready: go to IDLE and pulse done for exactly one cycle coinciding with IDLE entry.
- abort (any state other than IDLE): next cycle the state is IDLE, mem_valid=0, in_ready=0, no done pulse. wrap_err retains its value.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins, and the start is dropped.
- start while busy is ignored.
- rst_n asserted mid-load clears everything immediately, including any pending write. No done pulse.

Decomposition:
- Package isa_pkg holds:
  - OPCODE_W=3 and AUX_W=3.
  - Field bit positions: OPC_LSB=0, RT_BIT=3, RS_BIT=4, AUX_LSB=5.
  - INST_W=8.
  - State enum {IDLE, RUN, DRAIN}.
- The splitter and this block share isa_pkg.
- One combinational sub-module, instruction_packer: fields in, 8-bit word out. It is the exact inverse of the decoder and is unit-tested against it.

Test Plan:
- start base=0x10 count=3, feed (op=5,rt=1,rs=0,aux=6) with mem_ready=1 -> mem_addr=0x10, mem_wdata=0xCD, one cycle after accept.
- count=4 stream with mem_ready=1 throughout -> writes on 4 consecutive cycles at addresses base..base+3; done pulses once after the last write; busy falls with done.
- mem_ready held low 3 cycles while mem_valid=1 -> mem_addr/mem_wdata stable, in_ready=0, no tuple lost; resumes in order.
- base=0xFE count=3 (ADDR_W=8) -> writes at 0xFE, 0xFF, 0x00; wrap_err=1 stays set after done.
- abort after 2 of 5 tuples with a pending write -> mem_valid=0 next cycle, no done, IDLE; a subsequent start count=1 completes normally.
- start count=0 -> done pulses next cycle, no mem_valid; rst_n pulsed low mid-load -> all outputs return to reset values asynchronously.
